rv_sys_monitor: RTL and testbench

Synthesizable ecall/ebreak monitor for the rv32emc core. It observes the retire stream of one or more harts and decodes `SYS_exit` (93) and `SYS_write`-style putchar (64) requests. Exit status is reported after a programmable drain delay, and console characters are buffered in a FIFO that a testbench or UART consumes. It also provides a cycle counter and a watchdog timeout. It sits beside `rvc` at the top level and replaces per-bench ad-hoc ecall detection.

---
 rtl/rv_sys_monitor.sv | 192 +++++++++++++++++++
 tb/tb_rv_sys_monitor.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_sys_monitor.sv
// rtl/rv_sys_monitor.sv - ecall/ebreak retire monitor with console FIFO, drain timer and watchdog
module rv_sys_monitor #(
  parameter int unsigned N_HART      = 1,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DRAIN_CYC   = 5,
  parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000,
  parameter logic [31:0] SYS_EXIT    = 32'd93,
  parameter logic [31:0] SYS_PUTC    = 32'd64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_HART-1:0]      ret_v,
  input  logic [N_HART-1:0][31:0] ret_ir,
  input  logic [N_HART-1:0][31:0] ret_a7,
  input  logic [N_HART-1:0][31:0] ret_a0,
  output logic [7:0]             con_data,
  output logic                   con_valid,
  input  logic                   con_ready,
  output logic [15:0]            con_drop,
  output logic                   done,
  output logic [31:0]            exit_code,
  output logic [1:0]             exit_hart,
  output logic                   abort,
  output logic                   timeout,
  output logic [31:0]            cycles
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [31:0] IR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] IR_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   drain_q, drain_d;
  logic [31:0]   cycles_q, cycles_d;
  logic [31:0]   exit_code_q, exit_code_d;
  logic [1:0]    exit_hart_q, exit_hart_d;
  logic          abort_q, abort_d;
  logic          timeout_q, timeout_d;
  logic          done_q, done_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [7:0]    con_data_q, con_data_d;
  logic          con_valid_q, con_valid_d;
  logic [15:0]   con_drop_q, con_drop_d;

  logic          term_any, term_brk;
  logic [1:0]    term_idx;
  logic [31:0]   term_a0;
  logic          putc_any;
  logic [7:0]    putc_data;
  logic [2:0]    putc_cnt;
  logic          accept, pop, push, full, wd_hit;
  logic [2:0]    drop_inc;
  logic [16:0]   drop_sum;

  // Lowest-index hart wins both the termination and the console slot.
  always_comb begin
    term_any  = 1'b0;
    term_brk  = 1'b0;
    term_idx  = 2'd0;
    term_a0   = 32'd0;
    putc_any  = 1'b0;
    putc_data = 8'd0;
    putc_cnt  = 3'd0;
    for (int i = 0; i < N_HART; i++) begin
      if (ret_v[i]) begin
        if (!term_any && (ret_ir[i] == IR_EBREAK ||
                          (ret_ir[i] == IR_ECALL && ret_a7[i] == SYS_EXIT))) begin
          term_any = 1'b1;
          term_brk = (ret_ir[i] == IR_EBREAK);
          term_idx = 2'(i);
          term_a0  = ret_a0[i];
        end
        if (ret_ir[i] == IR_ECALL && ret_a7[i] == SYS_PUTC) begin
          if (!putc_any) putc_data = ret_a0[i][7:0];
          putc_any = 1'b1;
          putc_cnt = putc_cnt + 3'd1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    exit_code_d = exit_code_q;
    exit_hart_d = exit_hart_q;
    abort_d     = abort_q;
    timeout_d   = timeout_q;
    wd_hit      = (TIMEOUT_CYC != 32'd0) && (cycles_q + 32'd1 == TIMEOUT_CYC);
    case (state_q)
      ST_RUN: begin
        if (term_any) begin
          exit_code_d = term_a0;
          exit_hart_d = term_idx;
          abort_d     = term_brk;
          drain_d     = DRAIN_CYC;
          state_d     = ST_DRAIN;
        end else if (wd_hit) begin
          timeout_d   = 1'b1;
          exit_code_d = 32'hFFFF_FFFF;
          exit_hart_d = 2'd0;
          drain_d     = DRAIN_CYC;
          state_d     = ST_DRAIN;
        end
      end
      // A load of 0 or 1 both leave DRAIN after a single cycle.
      ST_DRAIN: begin
        if (drain_q <= 32'd1) state_d = ST_DONE;
        else                  drain_d = drain_q - 32'd1;
      end
      default: ;
    endcase
    done_d   = (state_d == ST_DONE);
    cycles_d = (state_q == ST_DONE) ? cycles_q : cycles_q + 32'd1;
  end

  always_comb begin
    accept   = (state_q != ST_DONE);
    pop      = con_valid_q && con_ready;
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push     = accept && putc_any && (!full || pop);
    drop_inc = accept ? (putc_cnt - {2'b00, push}) : 3'd0;
    drop_sum = {1'b0, con_drop_q} + {14'd0, drop_inc};
    con_drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q[AW-1:0]] = putc_data;

    // The head register must see a character pushed into an otherwise empty FIFO.
    con_valid_d = (wr_ptr_d != rd_ptr_d);
    con_data_d  = con_data_q;
    if (con_valid_d) begin
      if (push && rd_ptr_d == wr_ptr_q) con_data_d = putc_data;
      else                              con_data_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      drain_q     <= 32'd0;
      cycles_q    <= 32'd0;
      exit_code_q <= 32'd0;
      exit_hart_q <= 2'd0;
      abort_q     <= 1'b0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      con_data_q  <= 8'd0;
      con_valid_q <= 1'b0;
      con_drop_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cycles_q    <= cycles_d;
      exit_code_q <= exit_code_d;
      exit_hart_q <= exit_hart_d;
      abort_q     <= abort_d;
      timeout_q   <= timeout_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      con_data_q  <= con_data_d;
      con_valid_q <= con_valid_d;
      con_drop_q  <= con_drop_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign con_data  = con_data_q;
  assign con_valid = con_valid_q;
  assign con_drop  = con_drop_q;
  assign done      = done_q;
  assign exit_code = exit_code_q;
  assign exit_hart = exit_hart_q;
  assign abort     = abort_q;
  assign timeout   = timeout_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_rv_sys_monitor.sv
// tb/tb_rv_sys_monitor.sv - self-checking bench for rv_sys_monitor
module tb_rv_sys_monitor;

  localparam int NH    = 2;
  localparam int DEPTH = 4;
  localparam int DRAIN = 5;
  localparam int TMO   = 100;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic clk = 1'b0;
  logic reset;
  logic [NH-1:0]       ret_v;
  logic [NH-1:0][31:0] ret_ir, ret_a7, ret_a0;
  logic [7:0]  con_data;
  logic        con_valid, con_ready;
  logic [15:0] con_drop;
  logic        done, abort, timeout;
  logic [31:0] exit_code, cycles;
  logic [1:0]  exit_hart;

  always #5 clk = ~clk;

  rv_sys_monitor #(
    .N_HART(NH), .FIFO_DEPTH(DEPTH), .DRAIN_CYC(DRAIN), .TIMEOUT_CYC(32'(TMO)),
    .SYS_EXIT(32'd93), .SYS_PUTC(32'd64)
  ) dut (
    .clk(clk), .reset(reset), .ret_v(ret_v), .ret_ir(ret_ir), .ret_a7(ret_a7), .ret_a0(ret_a0),
    .con_data(con_data), .con_valid(con_valid), .con_ready(con_ready), .con_drop(con_drop),
    .done(done), .exit_code(exit_code), .exit_hart(exit_hart), .abort(abort),
    .timeout(timeout), .cycles(cycles)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a character queue plus "terminated at edge k" bookkeeping.
  byte unsigned m_q[$];
  int unsigned  m_drop, m_k, m_term_k;
  bit           m_term, m_abort, m_tmo;
  logic [31:0]  m_code, m_cycles;
  logic [1:0]   m_hart;

  function bit m_done_f();
    return m_term && (m_k >= m_term_k + ((DRAIN == 0) ? 1 : DRAIN));
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_drop = 0; m_k = 0; m_term_k = 0;
    m_term = 0; m_abort = 0; m_tmo = 0;
    m_code = 0; m_cycles = 0; m_hart = 0;
  endtask

  task automatic model_step();
    bit dn, first;
    dn = m_done_f();
    if (m_q.size() > 0 && con_ready) void'(m_q.pop_front());
    if (!dn) begin
      first = 1;
      for (int i = 0; i < NH; i++) begin
        if (ret_v[i] && ret_ir[i] == ECALL && ret_a7[i] == 32'd64) begin
          if (first && m_q.size() < DEPTH) m_q.push_back(ret_a0[i][7:0]);
          else if (m_drop < 32'hFFFF) m_drop++;
          first = 0;
        end
      end
    end
    if (!m_term) begin
      for (int i = 0; i < NH; i++) begin
        if (!m_term && ret_v[i] &&
            (ret_ir[i] == EBREAK || (ret_ir[i] == ECALL && ret_a7[i] == 32'd93))) begin
          m_term = 1; m_abort = (ret_ir[i] == EBREAK); m_code = ret_a0[i];
          m_hart = 2'(i); m_term_k = m_k + 1;
        end
      end
      if (!m_term && TMO != 0 && m_cycles + 32'd1 == 32'(TMO)) begin
        m_term = 1; m_tmo = 1; m_code = 32'hFFFF_FFFF; m_hart = 0; m_term_k = m_k + 1;
      end
    end
    if (!dn) m_cycles++;
    m_k++;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic idle();
    ret_v = '0; ret_ir = '0; ret_a7 = '0; ret_a0 = '0;
  endtask

  task automatic set_ev(input int h, input logic [31:0] ir, input logic [31:0] a7, input logic [31:0] a0);
    ret_v[h] = 1'b1; ret_ir[h] = ir; ret_a7[h] = a7; ret_a0[h] = a0;
  endtask

  task automatic pulse(input int h, input logic [31:0] ir, input logic [31:0] a7, input logic [31:0] a0);
    set_ev(h, ir, a7, a0);
    cyc();
    idle();
  endtask

  task automatic do_reset();
    idle();
    con_ready = 1'b0;
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (con_valid !== 1'b0) begin n_fail++; $display("FAIL rst_con_valid got %0h want 0", con_valid); end
    n_tests++; if (con_data !== 8'd0) begin n_fail++; $display("FAIL rst_con_data got %0h want 0", con_data); end
    n_tests++; if (con_drop !== 16'd0) begin n_fail++; $display("FAIL rst_con_drop got %0h want 0", con_drop); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %0h want 0", done); end
    n_tests++; if (abort !== 1'b0) begin n_fail++; $display("FAIL rst_abort got %0h want 0", abort); end
    n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout got %0h want 0", timeout); end
    n_tests++; if (exit_code !== 32'd0) begin n_fail++; $display("FAIL rst_exit_code got %0h want 0", exit_code); end
    n_tests++; if (exit_hart !== 2'd0) begin n_fail++; $display("FAIL rst_exit_hart got %0h want 0", exit_hart); end
    n_tests++; if (cycles !== 32'd0) begin n_fail++; $display("FAIL rst_cycles got %0h want 0", cycles); end
  endtask

  task automatic test_hello();
    int n;
    logic [31:0] c;
    do_reset();
    pulse(0, ECALL, 32'd64, 32'h48);
    n_tests++; if (con_valid !== 1'b1) begin n_fail++; $display("FAIL hello_valid got %0h want 1", con_valid); end
    n_tests++; if (con_data !== 8'h48) begin n_fail++; $display("FAIL hello_H got %0h want 48", con_data); end
    pulse(0, ECALL, 32'd64, 32'h69);
    n_tests++; if (con_data !== 8'h48) begin n_fail++; $display("FAIL hello_hold got %0h want 48", con_data); end
    pulse(0, ECALL, 32'd93, 32'd0);
    n_tests++; if (exit_code !== 32'd0 || exit_hart !== 2'd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL hello_exit got code %0h hart %0h done %0h want 0 0 0", exit_code, exit_hart, done); end
    n = 1;
    while (!done && n < 20) begin cyc(); n++; end
    n_tests++; if (n != 6) begin n_fail++; $display("FAIL hello_done_lat got %0d want 6", n); end
    n_tests++; if (cycles !== 32'd8) begin n_fail++; $display("FAIL hello_cycles got %0d want 8", cycles); end
    con_ready = 1'b1;
    cyc();
    n_tests++; if (con_valid !== 1'b1 || con_data !== 8'h69) begin
      n_fail++; $display("FAIL hello_i got v%0h %0h want v1 69", con_valid, con_data); end
    cyc();
    n_tests++; if (con_valid !== 1'b0) begin n_fail++; $display("FAIL hello_empty got %0h want 0", con_valid); end
    con_ready = 1'b0;
    c = cycles;
    cyc(); cyc();
    n_tests++; if (cycles !== 32'd8 || done !== 1'b1) begin
      n_fail++; $display("FAIL hello_frozen got cycles %0d done %0h want 8 1 (was %0d)", cycles, done, c); end
  endtask

  task automatic test_overflow();
    byte unsigned exp2 [4];
    do_reset();
    for (int i = 0; i < 6; i++) pulse(0, ECALL, 32'd64, 32'h61 + 32'(i));
    n_tests++; if (con_drop !== 16'd2) begin n_fail++; $display("FAIL ovf_drop got %0d want 2", con_drop); end
    con_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (con_valid !== 1'b1 || con_data !== 8'(8'h61 + i)) begin
        n_fail++; $display("FAIL ovf_drain%0d got v%0h %0h want v1 %0h", i, con_valid, con_data, 8'h61 + i); end
      cyc();
    end
    n_tests++; if (con_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %0h want 0", con_valid); end
    con_ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse(0, ECALL, 32'd64, 32'h77 + 32'(i));
    set_ev(0, ECALL, 32'd64, 32'h71);
    con_ready = 1'b1;
    cyc();
    idle();
    n_tests++; if (con_drop !== 16'd2) begin n_fail++; $display("FAIL ovf_pushpop_drop got %0d want 2", con_drop); end
    exp2[0] = 8'h78; exp2[1] = 8'h79; exp2[2] = 8'h7a; exp2[3] = 8'h71;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (con_valid !== 1'b1 || con_data !== exp2[i]) begin
        n_fail++; $display("FAIL ovf_pp%0d got v%0h %0h want v1 %0h", i, con_valid, con_data, exp2[i]); end
      cyc();
    end
    n_tests++; if (con_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_pp_empty got %0h want 0", con_valid); end
    con_ready = 1'b0;
  endtask

  task automatic test_multi_term();
    do_reset();
    set_ev(1, ECALL, 32'd93, 32'd7);
    set_ev(0, EBREAK, 32'd0, 32'd3);
    cyc(); idle();
    n_tests++; if (exit_hart !== 2'd0 || abort !== 1'b1 || exit_code !== 32'd3) begin
      n_fail++; $display("FAIL mt_brk0 got hart %0d abort %0h code %0d want 0 1 3", exit_hart, abort, exit_code); end
    pulse(0, ECALL, 32'd93, 32'd44);
    n_tests++; if (exit_code !== 32'd3) begin n_fail++; $display("FAIL mt_drain_ignore got %0d want 3", exit_code); end
    do_reset();
    set_ev(0, ECALL, 32'd93, 32'd5);
    set_ev(1, EBREAK, 32'd0, 32'd9);
    cyc(); idle();
    n_tests++; if (exit_hart !== 2'd0 || abort !== 1'b0 || exit_code !== 32'd5) begin
      n_fail++; $display("FAIL mt_exit0 got hart %0d abort %0h code %0d want 0 0 5", exit_hart, abort, exit_code); end
    do_reset();
    pulse(1, EBREAK, 32'd0, 32'd9);
    n_tests++; if (exit_hart !== 2'd1 || abort !== 1'b1 || exit_code !== 32'd9) begin
      n_fail++; $display("FAIL mt_brk1 got hart %0d abort %0h code %0d want 1 1 9", exit_hart, abort, exit_code); end
    do_reset();
    pulse(0, ECALL, 32'd17, 32'd1);
    set_ev(1, 32'h0000_0013, 32'd93, 32'd2);
    ret_v = '0;
    set_ev(0, 32'h0000_0013, 32'd64, 32'h41);
    cyc(); idle();
    for (int i = 0; i < 8; i++) cyc();
    n_tests++; if (done !== 1'b0 || con_valid !== 1'b0) begin
      n_fail++; $display("FAIL mt_ignore got done %0h valid %0h want 0 0", done, con_valid); end
  endtask

  task automatic test_dual_putc();
    do_reset();
    set_ev(0, ECALL, 32'd64, 32'h41);
    set_ev(1, ECALL, 32'd64, 32'h42);
    cyc(); idle();
    n_tests++; if (con_data !== 8'h41 || con_drop !== 16'd1) begin
      n_fail++; $display("FAIL dual got data %0h drop %0d want 41 1", con_data, con_drop); end
    con_ready = 1'b1;
    cyc();
    n_tests++; if (con_valid !== 1'b0) begin n_fail++; $display("FAIL dual_empty got %0h want 0", con_valid); end
    con_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int n, m;
    do_reset();
    n = 0;
    while (!timeout && n < 200) begin cyc(); n++; end
    n_tests++; if (n != TMO) begin n_fail++; $display("FAIL tmo_edge got %0d want %0d", n, TMO); end
    n_tests++; if (cycles !== 32'd100 || exit_code !== 32'hFFFF_FFFF || exit_hart !== 2'd0 || abort !== 1'b0) begin
      n_fail++; $display("FAIL tmo_state got cyc %0d code %0h hart %0d abort %0h want 100 ffffffff 0 0", cycles, exit_code, exit_hart, abort); end
    m = 0;
    while (!done && m < 20) begin cyc(); m++; end
    n_tests++; if (m != DRAIN) begin n_fail++; $display("FAIL tmo_done_lat got %0d want %0d", m, DRAIN); end
    cyc(); cyc(); cyc();
    n_tests++; if (cycles !== 32'd105 || done !== 1'b1 || timeout !== 1'b1) begin
      n_fail++; $display("FAIL tmo_frozen got cyc %0d done %0h tmo %0h want 105 1 1", cycles, done, timeout); end
  endtask

  task automatic test_reset_drain();
    int n;
    do_reset();
    for (int i = 0; i < 3; i++) pulse(0, ECALL, 32'd64, 32'h31 + 32'(i));
    pulse(0, ECALL, 32'd93, 32'd1);
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    n_tests++; if (con_valid !== 1'b0 || done !== 1'b0 || cycles !== 32'd0 || exit_code !== 32'd0) begin
      n_fail++; $display("FAIL rd_clear got v%0h done %0h cyc %0d code %0d want 0 0 0 0", con_valid, done, cycles, exit_code); end
    pulse(0, ECALL, 32'd93, 32'd93);
    n = 0;
    while (!done && n < 20) begin cyc(); n++; end
    n_tests++; if (done !== 1'b1 || exit_code !== 32'd93) begin
      n_fail++; $display("FAIL rd_exit got done %0h code %0d want 1 93", done, exit_code); end
  endtask

  task automatic test_random();
    int r;
    bit noterm;
    for (int ep = 0; ep < 6; ep++) begin
      noterm = (ep == 5);
      do_reset();
      for (int c = 0; c < 130; c++) begin
        for (int h = 0; h < NH; h++) begin
          r = $urandom_range(0, 99);
          ret_v[h] = (r < 60);
          r = $urandom_range(0, 99);
          ret_ir[h] = (r < 85) ? ECALL : (r < 86 && !noterm) ? EBREAK : 32'h0000_0013 + $urandom_range(0, 255);
          r = $urandom_range(0, 199);
          ret_a7[h] = (r < 140) ? 32'd64 : (r < 141 && !noterm) ? 32'd93 : 32'(100 + $urandom_range(0, 27));
          ret_a0[h] = $urandom();
        end
        con_ready = ($urandom_range(0, 99) < 40);
        cyc();
        n_tests++; if (con_valid !== (m_q.size() > 0)) begin
          n_fail++; $display("FAIL rnd_valid ep%0d c%0d got %0h want %0h", ep, c, con_valid, m_q.size() > 0); end
        if (m_q.size() > 0) begin
          n_tests++; if (con_data !== m_q[0]) begin
            n_fail++; $display("FAIL rnd_data ep%0d c%0d got %0h want %0h", ep, c, con_data, m_q[0]); end
        end
        n_tests++; if (con_drop !== 16'(m_drop)) begin
          n_fail++; $display("FAIL rnd_drop ep%0d c%0d got %0d want %0d", ep, c, con_drop, m_drop); end
        n_tests++; if (done !== m_done_f() || abort !== m_abort || timeout !== m_tmo) begin
          n_fail++; $display("FAIL rnd_flags ep%0d c%0d got %0h%0h%0h want %0h%0h%0h", ep, c, done, abort, timeout, m_done_f(), m_abort, m_tmo); end
        n_tests++; if (exit_code !== m_code || exit_hart !== m_hart) begin
          n_fail++; $display("FAIL rnd_exit ep%0d c%0d got %0h/%0d want %0h/%0d", ep, c, exit_code, exit_hart, m_code, m_hart); end
        n_tests++; if (cycles !== m_cycles) begin
          n_fail++; $display("FAIL rnd_cycles ep%0d c%0d got %0d want %0d", ep, c, cycles, m_cycles); end
      end
      idle();
    end
  endtask

  initial begin
    reset = 1'b1;
    con_ready = 1'b0;
    idle();
    model_reset();
    test_reset();
    test_hello();
    test_overflow();
    test_multi_term();
    test_dual_putc();
    test_timeout();
    test_reset_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
